// File: rtl/led_chaser_pkg.sv
// led_chaser_pkg
// Shared definitions for the LED chaser:
//   - mode encodings for the mode select input
//   - clog2 helper used to size counters and the step index
//   - params_legal helper that the top uses to reject bad parameter sets
package led_chaser_pkg;

    localparam logic [1:0] MODE_SWEEP  = 2'd0;
    localparam logic [1:0] MODE_BOUNCE = 2'd1;
    localparam logic [1:0] MODE_FILL   = 2'd2;
    localparam logic [1:0] MODE_HOLD   = 2'd3;

    // Number of bits needed to hold values 0..value-1 (0 for value <= 1).
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result = result + 1;
        end
        return result;
    endfunction

    // LEDs must split evenly into groups, and the prescaler needs at least
    // two clocks per step.
    function automatic bit params_legal(input int num_leds, input int group,
                                        input int tick_div);
        return (group > 0) && (num_leds >= group) &&
               (num_leds % group == 0) && (tick_div >= 2);
    endfunction

endpackage

// File: rtl/led_tick_gen.sv
// led_tick_gen
// Step prescaler for the LED chaser. Counts enabled clocks and raises
// tick for the single clock in which the count sits at TICK_DIV-1, so a
// tick occurs every TICK_DIV enabled clocks.
// Ports:
//   clk     - system clock, rising edge
//   reset_n - asynchronous active-low reset
//   en      - count enable; low preserves the partial count
//   clear   - synchronous clear, wins over en and suppresses tick
//   tick    - combinational step request, valid in the terminal-count clock
module led_tick_gen
    import led_chaser_pkg::*;
#(
    parameter int TICK_DIV = 25_000_000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic en,
    input  logic clear,
    output logic tick
);

    localparam int               CNT_W   = clog2(TICK_DIV);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt;

    // A clear in the same clock as terminal count must not produce a step,
    // so tick is masked by clear as well as gated by en.
    assign tick = en && !clear && (cnt == CNT_MAX);

    // Prescaler counter: clear has priority, then wrap at terminal count.
    // When en is low the count is simply held, so a frozen step resumes
    // exactly where it left off.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (en) begin
            if (cnt == CNT_MAX) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/led_chaser_n.sv
// led_chaser_n
// Parametrised LED pattern sequencer. A prescaler paces a step index that
// walks a mode-selected pattern (SWEEP, BOUNCE, FILL) across NUM_LEDS
// outputs lit in groups of GROUP; HOLD freezes everything.
// Ports:
//   clk     - system clock, rising edge
//   reset_n - asynchronous active-low reset
//   en      - run enable; low freezes prescaler and step index
//   dir     - 1: travel high group to low group, 0: low to high
//   mode    - 0 SWEEP, 1 BOUNCE, 2 FILL, 3 HOLD
//   leds    - registered LED drive, active-high, one clock behind idx
//   step    - one-clock pulse in the cycle idx takes its new value
//   idx_o   - current step index
module led_chaser_n
    import led_chaser_pkg::*;
#(
    parameter int NUM_LEDS = 10,
    parameter int GROUP    = 2,
    parameter int TICK_DIV = 25_000_000,
    parameter int IDX_W    = clog2(NUM_LEDS / GROUP + 2)
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                en,
    input  logic                dir,
    input  logic [1:0]          mode,
    output logic [NUM_LEDS-1:0] leds,
    output logic                step,
    output logic [IDX_W-1:0]    idx_o
);

    localparam int P = NUM_LEDS / GROUP;

    localparam logic [IDX_W-1:0] IDX_SWEEP_LAST = IDX_W'(P + 1);
    localparam logic [IDX_W-1:0] IDX_FILL_LAST  = IDX_W'(P);
    localparam logic [IDX_W-1:0] IDX_POS_LAST   = IDX_W'(P - 1);

    if (!params_legal(NUM_LEDS, GROUP, TICK_DIV)) begin : g_bad_params
        $error("led_chaser_n: NUM_LEDS must be a multiple of GROUP and TICK_DIV >= 2");
    end

    logic [IDX_W-1:0]    idx;
    logic [IDX_W-1:0]    idx_next;
    logic                bdir;
    logic                bdir_next;
    logic [1:0]          last_mode;
    logic                hold;
    logic                restart;
    logic                tick;
    logic [P-1:0]        pos_mask;
    logic [NUM_LEDS-1:0] pattern;

    assign hold    = (mode == MODE_HOLD);
    assign restart = !hold && (mode != last_mode);
    assign idx_o   = idx;

    led_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (en && !hold),
        .clear   (restart),
        .tick    (tick)
    );

    // Next index for each mode. BOUNCE turns around on the end position
    // itself rather than repeating it, giving a 2P-2 step period; with a
    // single position there is nowhere to go and the index stays at 0.
    always_comb begin
        idx_next  = idx;
        bdir_next = bdir;
        case (mode)
            MODE_SWEEP: idx_next = (idx >= IDX_SWEEP_LAST) ? '0 : idx + IDX_W'(1);
            MODE_FILL:  idx_next = (idx >= IDX_FILL_LAST) ? '0 : idx + IDX_W'(1);
            MODE_BOUNCE: begin
                if (P > 1) begin
                    if (!bdir) begin
                        if (idx >= IDX_POS_LAST) begin
                            bdir_next = 1'b1;
                            idx_next  = idx - IDX_W'(1);
                        end else begin
                            idx_next = idx + IDX_W'(1);
                        end
                    end else begin
                        if (idx == '0) begin
                            bdir_next = 1'b0;
                            idx_next  = IDX_W'(1);
                        end else begin
                            idx_next = idx - IDX_W'(1);
                        end
                    end
                end
            end
            default: idx_next = idx;
        endcase
    end

    // Pattern decode in two stages: first which travel positions are lit,
    // then map positions onto physical groups according to dir. Keeping
    // dir out of the first stage lets a dir flip take effect on the very
    // next leds update without touching the sequence state.
    always_comb begin
        pos_mask = '0;
        pattern  = '0;
        for (int p = 0; p < P; p++) begin
            case (mode)
                MODE_SWEEP:  pos_mask[p] = (idx == '0) || (idx == IDX_W'(p + 1));
                MODE_BOUNCE: pos_mask[p] = (idx == IDX_W'(p));
                MODE_FILL:   pos_mask[p] = (idx > IDX_W'(p));
                default:     pos_mask[p] = 1'b0;
            endcase
        end
        for (int g = 0; g < P; g++) begin
            pattern[g*GROUP +: GROUP] = {GROUP{dir ? pos_mask[P-1-g] : pos_mask[g]}};
        end
    end

    // Sequence state and registered outputs. HOLD freezes idx, bdir and
    // leds and keeps step low. A switch to a different running mode
    // restarts the sequence and takes priority over any coincident tick;
    // last_mode only tracks running modes, so passing through HOLD back
    // into the same mode resumes rather than restarting.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            idx       <= '0;
            bdir      <= 1'b0;
            last_mode <= MODE_SWEEP;
            leds      <= '0;
            step      <= 1'b0;
        end else if (hold) begin
            step <= 1'b0;
        end else begin
            leds <= pattern;
            if (restart) begin
                idx       <= '0;
                bdir      <= 1'b0;
                last_mode <= mode;
                step      <= 1'b0;
            end else begin
                step <= tick;
                if (tick) begin
                    idx  <= idx_next;
                    bdir <= bdir_next;
                end
            end
        end
    end

endmodule

// File: tb/tb_led_chaser_n.sv
// tb_led_chaser_n
// Directed bench for led_chaser_n with NUM_LEDS=10, GROUP=2, TICK_DIV=4.
// Walks SWEEP in both directions, BOUNCE, FILL, then freeze, HOLD,
// mode-change restart and asynchronous mid-run reset, comparing against
// hand-computed LED words and index values.
module tb_led_chaser_n;

    import led_chaser_pkg::*;

    logic       clk;
    logic       reset_n;
    logic       en;
    logic       dir;
    logic [1:0] mode;
    logic [9:0] leds;
    logic       step;
    logic [2:0] idx_o;

    int checks;
    int errors;

    logic [9:0] expSeq[$];

    led_chaser_n #(
        .NUM_LEDS (10),
        .GROUP    (2),
        .TICK_DIV (4)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (en),
        .dir     (dir),
        .mode    (mode),
        .leds    (leds),
        .step    (step),
        .idx_o   (idx_o)
    );

    // 10 time-unit clock; outputs are sampled on the falling edge.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Drive the control inputs.
    task automatic applyStimulus(input logic newEn, input logic newDir,
                                 input logic [1:0] newMode);
        en   = newEn;
        dir  = newDir;
        mode = newMode;
    endtask

    // Advance one rising edge and land on the following falling edge.
    task automatic tickClk();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Hold reset for two clocks with the given inputs, release on a falling edge.
    task automatic doReset(input logic newEn, input logic newDir,
                           input logic [1:0] newMode);
        reset_n = 1'b0;
        applyStimulus(newEn, newDir, newMode);
        repeat (2) tickClk();
        reset_n = 1'b1;
    endtask

    // Each expSeq entry must be held for 4 clocks, with step high in the
    // last of those 4 samples (idx advances one clock before leds follows).
    task automatic runSequence(input string name);
        for (int j = 0; j < expSeq.size(); j++) begin
            for (int c = 0; c < 4; c++) begin
                tickClk();
                checkOutput($sformatf("%s leds[%0d.%0d]", name, j, c), 32'(leds), 32'(expSeq[j]));
                checkOutput($sformatf("%s step[%0d.%0d]", name, j, c), 32'(step), (c == 3) ? 32'd1 : 32'd0);
            end
        end
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        reset_n = 1'b0;
        applyStimulus(1'b1, 1'b1, MODE_SWEEP);

        // Reset state
        doReset(1'b1, 1'b1, MODE_SWEEP);
        checkOutput("reset leds", 32'(leds), 32'h0);
        checkOutput("reset step", 32'(step), 32'h0);
        checkOutput("reset idx", 32'(idx_o), 32'h0);

        // SWEEP, high to low
        expSeq = '{10'h3FF, 10'h300, 10'h0C0, 10'h030, 10'h00C, 10'h003, 10'h000, 10'h3FF};
        runSequence("sweep_d1");

        // SWEEP, low to high
        doReset(1'b1, 1'b0, MODE_SWEEP);
        expSeq = '{10'h3FF, 10'h003, 10'h00C, 10'h030, 10'h0C0, 10'h300, 10'h000, 10'h3FF};
        runSequence("sweep_d0");

        // BOUNCE: first clock after release is a restart (mode differs from
        // reset's SWEEP), so the first position is held one extra clock.
        doReset(1'b1, 1'b0, MODE_BOUNCE);
        tickClk();
        checkOutput("bounce restart idx", 32'(idx_o), 32'h0);
        checkOutput("bounce restart leds", 32'(leds), 32'h003);
        expSeq = '{10'h003, 10'h00C, 10'h030, 10'h0C0, 10'h300,
                   10'h0C0, 10'h030, 10'h00C, 10'h003};
        runSequence("bounce_d0");

        // FILL, high to low, same restart clock as BOUNCE
        doReset(1'b1, 1'b1, MODE_FILL);
        tickClk();
        checkOutput("fill restart leds", 32'(leds), 32'h000);
        expSeq = '{10'h000, 10'h300, 10'h3C0, 10'h3F0, 10'h3FC, 10'h3FF, 10'h000};
        runSequence("fill_d1");

        // Freeze with en=0 at idx 1, cnt 2
        doReset(1'b1, 1'b1, MODE_SWEEP);
        repeat (6) tickClk();
        checkOutput("pre-freeze idx", 32'(idx_o), 32'h1);
        applyStimulus(1'b0, 1'b1, MODE_SWEEP);
        for (int i = 0; i < 10; i++) begin
            tickClk();
            checkOutput($sformatf("freeze idx[%0d]", i), 32'(idx_o), 32'h1);
            checkOutput($sformatf("freeze step[%0d]", i), 32'(step), 32'h0);
            checkOutput($sformatf("freeze leds[%0d]", i), 32'(leds), 32'h300);
        end
        applyStimulus(1'b1, 1'b1, MODE_SWEEP);
        tickClk();
        checkOutput("unfreeze +1 step", 32'(step), 32'h0);
        checkOutput("unfreeze +1 idx", 32'(idx_o), 32'h1);
        tickClk();
        checkOutput("unfreeze +2 step", 32'(step), 32'h1);
        checkOutput("unfreeze +2 idx", 32'(idx_o), 32'h2);

        // SWEEP -> HOLD -> SWEEP resumes at idx 2, cnt 1
        tickClk();
        checkOutput("pre-hold leds", 32'(leds), 32'h0C0);
        applyStimulus(1'b1, 1'b1, MODE_HOLD);
        for (int i = 0; i < 6; i++) begin
            tickClk();
            checkOutput($sformatf("hold idx[%0d]", i), 32'(idx_o), 32'h2);
            checkOutput($sformatf("hold step[%0d]", i), 32'(step), 32'h0);
            checkOutput($sformatf("hold leds[%0d]", i), 32'(leds), 32'h0C0);
        end
        applyStimulus(1'b1, 1'b1, MODE_SWEEP);
        tickClk();
        checkOutput("resume +1 idx", 32'(idx_o), 32'h2);
        checkOutput("resume +1 leds", 32'(leds), 32'h0C0);
        tickClk();
        checkOutput("resume +2 step", 32'(step), 32'h0);
        tickClk();
        checkOutput("resume +3 step", 32'(step), 32'h1);
        checkOutput("resume +3 idx", 32'(idx_o), 32'h3);

        // SWEEP -> FILL mid-step restarts the sequence
        tickClk();
        checkOutput("pre-fill leds", 32'(leds), 32'h030);
        applyStimulus(1'b1, 1'b1, MODE_FILL);
        tickClk();
        checkOutput("mode change idx", 32'(idx_o), 32'h0);
        checkOutput("mode change step", 32'(step), 32'h0);
        tickClk();
        checkOutput("mode change leds", 32'(leds), 32'h000);

        // Asynchronous reset between edges at idx 3
        doReset(1'b1, 1'b1, MODE_SWEEP);
        repeat (13) tickClk();
        checkOutput("pre-reset idx", 32'(idx_o), 32'h3);
        checkOutput("pre-reset leds", 32'(leds), 32'h030);
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("async reset leds", 32'(leds), 32'h0);
        checkOutput("async reset idx", 32'(idx_o), 32'h0);
        checkOutput("async reset step", 32'(step), 32'h0);
        #1;
        reset_n = 1'b1;
        tickClk();
        checkOutput("post-reset leds", 32'(leds), 32'h3FF);
        checkOutput("post-reset idx", 32'(idx_o), 32'h0);
        repeat (4) tickClk();
        checkOutput("post-reset step 1 leds", 32'(leds), 32'h300);
        checkOutput("post-reset step 1 idx", 32'(idx_o), 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
